xgmii_rx_frame_mon: RTL and testbench

Receive-side XGMII frame monitor. It sits on the `xgmii_rxd`/`xgmii_rxc` output of `eth_phy_10g`, which is the decode end of the path the transmit stimulus drives. It delineates frames (Start, Terminate), checks the preamble and SFD, measures frame length and the preceding inter-packet gap, and flags coding errors. It is used both in benches and in hardware for IPG and EDM measurements.

---
 rtl/xgmii_pkg.sv | 19 +
 rtl/xgmii_ctrl_lane_find.sv | 35 +++
 rtl/xgmii_rx_frame_mon.sv | 139 +++++++++++++
 tb/tb_xgmii_rx_frame_mon.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/xgmii_pkg.sv
// xgmii_pkg: XGMII character constants, monitor FSM states and frame error bit indices.
package xgmii_pkg;
  localparam logic [7:0] C_IDLE   = 8'h07;
  localparam logic [7:0] C_START  = 8'hFB;
  localparam logic [7:0] C_TERM   = 8'hFD;
  localparam logic [7:0] C_ERROR  = 8'hFE;
  localparam logic [7:0] PRE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;
  localparam int ERR_CTRL  = 0;
  localparam int ERR_PRE   = 1;
  localparam int ERR_LONG  = 2;
  localparam int ERR_ABORT = 3;
  typedef enum logic [1:0] {ST_IDLE, ST_PRE_HI, ST_DATA} state_t;
  typedef enum logic [1:0] {LT_TERM, LT_START, LT_ERROR, LT_OTHER} lane_t;
  function automatic logic [3:0] ones8(input logic [7:0] v);
    ones8 = '0;
    for (int i = 0; i < 8; i++) ones8 = ones8 + {3'b0, v[i]};
  endfunction
endpackage

// File: rtl/xgmii_ctrl_lane_find.sv
// xgmii_ctrl_lane_find: locates the lowest control lane of an XGMII word, classifies it,
// and reports whether the lanes above it are Idle.
module xgmii_ctrl_lane_find
  import xgmii_pkg::*;
(
  input  logic [63:0] rxd,
  input  logic [7:0]  rxc,
  output logic [2:0]  lane,
  output logic        found,
  output lane_t       ltype,
  output logic        hi_idle,
  output logic        hi_idle_lo
);
  logic [7:0][7:0] ln;
  logic [7:0] idle;
  logic [7:0] ch;
  assign ln = rxd;
  always_comb begin
    lane = '0;
    found = 1'b0;
    for (int k = 7; k >= 0; k--) if (rxc[k]) begin lane = 3'(k); found = 1'b1; end
    ch = ln[lane];
    ltype = ch == C_TERM ? LT_TERM : ch == C_START ? LT_START : ch == C_ERROR ? LT_ERROR : LT_OTHER;
    hi_idle = 1'b1;
    hi_idle_lo = 1'b1;
    for (int k = 0; k < 8; k++) begin
      idle[k] = rxc[k] && ln[k] == C_IDLE;
      // hi_idle_lo only covers lanes below 4, where a same-word lane-4 Start may follow
      if (k > int'(lane) && !idle[k]) begin
        hi_idle = 1'b0;
        if (k < 4) hi_idle_lo = 1'b0;
      end
    end
  end
endmodule

// File: rtl/xgmii_rx_frame_mon.sv
// xgmii_rx_frame_mon: XGMII receive frame monitor (delineation, preamble/SFD, length, IPG, errors).
// Define XGMII_MON_STATS_EN to build the good/bad frame counters.
module xgmii_rx_frame_mon
  import xgmii_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int CTRL_WIDTH    = 8,
  parameter int LEN_WIDTH     = 14,
  parameter int MAX_FRAME_LEN = 9600
) (
  input  logic                  rx_clk,
  input  logic                  rx_rst_n,
  input  logic [DATA_WIDTH-1:0] xgmii_rxd,
  input  logic [CTRL_WIDTH-1:0] xgmii_rxc,
  output logic                  frame_valid,
  output logic [LEN_WIDTH-1:0]  frame_len,
  output logic [3:0]            frame_err,
  output logic [15:0]           ipg_bytes,
  output logic [31:0]           good_frames,
  output logic [31:0]           bad_frames
);
  localparam int CW = LEN_WIDTH + 1;
  state_t state;
  logic [CW-1:0] len_cnt, fin_len;
  logic [CW:0] len_sum;
  logic [15:0] ipg_cnt, ipg_lat, gap_ipg, start_ipg;
  logic [16:0] gap_sum, start_sum;
  logic [3:0] err, cur_err, base, dbytes, idle_above;
  logic [7:0][7:0] ln;
  logic [7:0] is_idle, is_start, scan_rxc, above_mask;
  logic start0, start4, stray, pre0_ok, pre4_hi_ok, pre4_ok, prehi_ok;
  logic [2:0] lane;
  logic found, hi_idle, hi_idle_lo, term, sop, new_s4;
  lane_t ltype;
  assign ln = xgmii_rxd;
  xgmii_ctrl_lane_find u_find (
    .rxd        (xgmii_rxd),
    .rxc        (scan_rxc),
    .lane       (lane),
    .found      (found),
    .ltype      (ltype),
    .hi_idle    (hi_idle),
    .hi_idle_lo (hi_idle_lo)
  );
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      is_idle[k] = xgmii_rxc[k] && ln[k] == C_IDLE;
      is_start[k] = xgmii_rxc[k] && ln[k] == C_START;
    end
    start0 = is_start[0];
    start4 = is_start[4];
    stray = |(is_start & 8'hEE);
    pre0_ok = xgmii_rxc[7:1] == 7'b0 && ln[7] == SFD_BYTE;
    for (int k = 1; k < 7; k++) pre0_ok = pre0_ok && ln[k] == PRE_BYTE;
    pre4_hi_ok = xgmii_rxc[7:5] == 3'b0 && ln[5] == PRE_BYTE && ln[6] == PRE_BYTE && ln[7] == PRE_BYTE;
    pre4_ok = &is_idle[3:0] && pre4_hi_ok;
    prehi_ok = xgmii_rxc[3:0] == 4'b0 && ln[0] == PRE_BYTE && ln[1] == PRE_BYTE && ln[2] == PRE_BYTE && ln[3] == SFD_BYTE;
    // lanes 0-3 of the PRE_HI word are preamble, so only lanes 4-7 are scanned as frame data
    scan_rxc = state == ST_PRE_HI ? xgmii_rxc & 8'hF0 : xgmii_rxc;
    base = state == ST_PRE_HI ? 4'd4 : 4'd0;
    term = found && ltype == LT_TERM;
    sop = found && ltype == LT_START;
    dbytes = (term || sop) ? {1'b0, lane} - base : 4'd8 - base;
    len_sum = {1'b0, len_cnt} + (CW+1)'(dbytes);
    fin_len = len_sum[CW] ? '1 : len_sum[CW-1:0];
    new_s4 = term && start4 && lane <= 3'd2 && hi_idle_lo;
    cur_err = err;
    cur_err[ERR_PRE] = err[ERR_PRE] | (state == ST_PRE_HI && !prehi_ok);
    cur_err[ERR_CTRL] = err[ERR_CTRL] | (found && !term && !sop) | (term && !(hi_idle || new_s4));
    cur_err[ERR_LONG] = fin_len > CW'(MAX_FRAME_LEN);
    cur_err[ERR_ABORT] = sop;
    gap_sum = {1'b0, ipg_cnt} + 17'(ones8(is_idle)) + 17'(stray);
    gap_ipg = gap_sum[16] ? '1 : gap_sum[15:0];
    start_sum = {1'b0, ipg_cnt} + 17'(ones8(is_idle & 8'h0F));
    start_ipg = start_sum[16] ? '1 : start_sum[15:0];
    above_mask = ~((8'd2 << lane) - 8'd1);
    idle_above = ones8(is_idle & above_mask);
  end
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state <= ST_IDLE;
      len_cnt <= '0;
      ipg_cnt <= '0;
      ipg_lat <= '0;
      err <= '0;
      frame_valid <= 1'b0;
      frame_len <= '0;
      frame_err <= '0;
      ipg_bytes <= '0;
    end else begin
      frame_valid <= 1'b0;
      if (state == ST_IDLE) begin
        if (start0 || start4) begin
          state <= start0 ? ST_DATA : ST_PRE_HI;
          ipg_lat <= start0 ? ipg_cnt : start_ipg;
          err <= (start0 ? !pre0_ok : !pre4_ok) ? 4'(1 << ERR_PRE) : 4'b0;
          len_cnt <= '0;
        end else ipg_cnt <= gap_ipg;
      end else if (term || sop) begin
        frame_valid <= 1'b1;
        frame_len <= fin_len[CW-1] ? '1 : fin_len[LEN_WIDTH-1:0];
        frame_err <= cur_err;
        ipg_bytes <= ipg_lat;
        len_cnt <= '0;
        ipg_cnt <= '0;
        if (new_s4 || (sop && lane == 3'd4)) begin
          state <= ST_PRE_HI;
          ipg_lat <= new_s4 ? 16'd3 - 16'(lane) : 16'(ones8(is_idle & 8'h0F));
          err <= (new_s4 ? !pre4_hi_ok : !pre4_ok) ? 4'(1 << ERR_PRE) : 4'b0;
        end else if (sop && lane == 3'd0) begin
          state <= ST_DATA;
          ipg_lat <= '0;
          err <= !pre0_ok ? 4'(1 << ERR_PRE) : 4'b0;
        end else begin
          state <= ST_IDLE;
          if (term) ipg_cnt <= 16'(idle_above);
        end
      end else begin
        len_cnt <= fin_len;
        err <= cur_err;
        state <= ST_DATA;
      end
    end
  end
`ifdef XGMII_MON_STATS_EN
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      good_frames <= '0;
      bad_frames <= '0;
    end else if (frame_valid) begin
      if (frame_err == 4'b0) good_frames <= good_frames + 32'd1;
      else bad_frames <= bad_frames + 32'd1;
    end
  end
`else
  assign good_frames = '0;
  assign bad_frames = '0;
`endif
endmodule

// File: tb/tb_xgmii_rx_frame_mon.sv
// tb_xgmii_rx_frame_mon: directed self-checking bench for xgmii_rx_frame_mon.
module tb_xgmii_rx_frame_mon;
  localparam logic [63:0] IDLE_W = 64'h0707070707070707;
  localparam logic [63:0] SOP0_W = 64'hD5555555555555FB;
  localparam logic [63:0] DATA_W = 64'h0123456789ABCDEF;
  localparam logic [63:0] TERM0_W = 64'h07070707070707FD;
  logic rx_clk = 1'b0, rx_rst_n = 1'b1;
  logic [63:0] xgmii_rxd = '0;
  logic [7:0] xgmii_rxc = '0;
  logic frame_valid;
  logic [13:0] frame_len;
  logic [3:0] frame_err;
  logic [15:0] ipg_bytes;
  logic [31:0] good_frames, bad_frames;
  int checks = 0, errors = 0;
  logic [13:0] lq[$];
  logic [3:0] eq[$];
  logic [15:0] iq[$];
  xgmii_rx_frame_mon dut (
    .rx_clk      (rx_clk),
    .rx_rst_n    (rx_rst_n),
    .xgmii_rxd   (xgmii_rxd),
    .xgmii_rxc   (xgmii_rxc),
    .frame_valid (frame_valid),
    .frame_len   (frame_len),
    .frame_err   (frame_err),
    .ipg_bytes   (ipg_bytes),
    .good_frames (good_frames),
    .bad_frames  (bad_frames)
  );
  always #5 rx_clk = ~rx_clk;
  always @(negedge rx_clk) if (frame_valid) begin
    lq.push_back(frame_len);
    eq.push_back(frame_err);
    iq.push_back(ipg_bytes);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [63:0] d, input logic [7:0] c);
    @(negedge rx_clk);
    xgmii_rxd = d;
    xgmii_rxc = c;
  endtask
  task automatic idles(input int n);
    repeat (n) send(IDLE_W, 8'hFF);
  endtask
  task automatic do_reset;
    @(negedge rx_clk);
    rx_rst_n = 1'b0;
    xgmii_rxd = '0;
    xgmii_rxc = '0;
    repeat (2) @(negedge rx_clk);
    rx_rst_n = 1'b1;
  endtask
  task automatic expect_frame(input string tag, input int len, input int e, input int ipg);
    chk({tag, ".valid"}, 32'(lq.size() > 0), 32'd1);
    if (lq.size() > 0) begin
      chk({tag, ".len"}, 32'(lq.pop_front()), 32'(len));
      chk({tag, ".err"}, 32'(eq.pop_front()), 32'(e));
      chk({tag, ".ipg"}, 32'(iq.pop_front()), 32'(ipg));
    end
  endtask
  task automatic no_more(input string tag);
    chk({tag, ".extra"}, 32'(lq.size()), 32'd0);
  endtask
  task automatic chk_stats(input string tag, input int g, input int b);
`ifdef XGMII_MON_STATS_EN
    chk({tag, ".good"}, good_frames, 32'(g));
    chk({tag, ".bad"}, bad_frames, 32'(b));
`else
    chk({tag, ".good"}, good_frames, 32'd0);
    chk({tag, ".bad"}, bad_frames, 32'd0);
`endif
  endtask
  task automatic long_frame(input string tag, input int words, input int len, input int e);
    do_reset();
    send(SOP0_W, 8'h01);
    repeat (words) send(DATA_W, 8'h00);
    send(TERM0_W, 8'hFF);
    idles(2);
    expect_frame(tag, len, e, 0);
    no_more(tag);
  endtask
  initial begin
    do_reset();
    chk("rst.valid", 32'(frame_valid), 32'd0);
    chk("rst.len", 32'(frame_len), 32'd0);
    chk("rst.err", 32'(frame_err), 32'd0);
    chk("rst.ipg", 32'(ipg_bytes), 32'd0);
    chk_stats("rst", 0, 0);
    // lane-0 start, Terminate in lane 7
    idles(2);
    send(SOP0_W, 8'h01);
    send(64'h1111111111111111, 8'h00);
    send(64'h2222222222222222, 8'h00);
    send(64'hFD2233EE44EEEFFF, 8'h80);
    idles(2);
    expect_frame("lane0", 23, 0, 16);
    no_more("lane0");
    chk_stats("lane0", 1, 0);
    // lane-4 start
    do_reset();
    send(64'h555555FB07070707, 8'h1F);
    send(64'h44332211D5555555, 8'h00);
    send(TERM0_W, 8'hFF);
    idles(2);
    expect_frame("lane4", 4, 0, 4);
    no_more("lane4");
    // bad SFD
    do_reset();
    send(64'hD4555555555555FB, 8'h01);
    send(DATA_W, 8'h00);
    send(TERM0_W, 8'hFF);
    idles(2);
    expect_frame("badsfd", 8, 4'b0010, 0);
    no_more("badsfd");
    chk_stats("badsfd", 0, 1);
    // Error character mid-frame, Terminate at lane 2
    do_reset();
    idles(1);
    send(SOP0_W, 8'h01);
    send(64'h11111111FE111111, 8'h08);
    send(DATA_W, 8'h00);
    send(64'h0707070707FD2211, 8'hFC);
    idles(2);
    expect_frame("errch", 18, 4'b0001, 8);
    no_more("errch");
    // Terminate at lane 1 followed by lane-4 Start in the same word
    do_reset();
    send(SOP0_W, 8'h01);
    send(DATA_W, 8'h00);
    send(64'h555555FB0707FDAA, 8'h1E);
    send(64'h44332211D5555555, 8'h00);
    send(TERM0_W, 8'hFF);
    idles(2);
    expect_frame("b2b.a", 9, 0, 0);
    expect_frame("b2b.b", 4, 0, 2);
    no_more("b2b");
    // abort by a lane-0 Start inside a frame
    do_reset();
    idles(1);
    send(SOP0_W, 8'h01);
    send(DATA_W, 8'h00);
    send(SOP0_W, 8'h01);
    send(DATA_W, 8'h00);
    send(TERM0_W, 8'hFF);
    idles(2);
    expect_frame("abort.a", 8, 4'b1000, 8);
    expect_frame("abort.b", 8, 0, 0);
    no_more("abort");
    chk_stats("abort", 1, 1);
    // reset mid-frame drops the frame and restarts the IPG count
    idles(1);
    send(SOP0_W, 8'h01);
    send(DATA_W, 8'h00);
    do_reset();
    chk("midrst.nopulse", 32'(lq.size()), 32'd0);
    chk_stats("midrst", 0, 0);
    idles(1);
    send(SOP0_W, 8'h01);
    send(TERM0_W, 8'hFF);
    idles(2);
    expect_frame("midrst", 0, 0, 8);
    no_more("midrst");
    // length limits and saturation
    long_frame("max", 1200, 9600, 0);
    long_frame("over", 1201, 9608, 4'b0100);
    long_frame("sat", 2100, 14'h3FFF, 4'b0100);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
